// File: rtl/sprite_motion_ctrl.sv
// Frame-locked sprite motion/colour sequencer: steps the sprite origin one pixel
// per divided frame during blanking and cycles colour on every edge hit.
module sprite_motion_ctrl #(
  parameter int unsigned X_MIN   = 216,
  parameter int unsigned X_MAX   = 1016,
  parameter int unsigned Y_MIN   = 27,
  parameter int unsigned Y_MAX   = 627,
  parameter int unsigned P_WIDTH = 128,
  parameter int unsigned P_DEPTH = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_start_i,
  input  logic        enable_i,
  input  logic [3:0]  speed_i,
  output logic [15:0] x_set_o,
  output logic [15:0] y_set_o,
  output logic [2:0]  color_o,
  output logic        upd_o,
  output logic        bounce_o
);

  localparam logic [15:0] X_LO = 16'(X_MIN);
  localparam logic [15:0] X_HI = 16'(X_MAX - P_WIDTH);
  localparam logic [15:0] Y_LO = 16'(Y_MIN);
  localparam logic [15:0] Y_HI = 16'(Y_MAX - P_DEPTH);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] CYAN   = 3'b011;
  localparam logic [2:0] PURPLE = 3'b101;

  typedef enum logic [1:0] {
    S_WAIT,
    S_MOVE_X,
    S_MOVE_Y,
    S_COMMIT
  } state_t;

  state_t      state_q;
  logic [3:0]  frame_cnt_q;
  logic        x_dir_q, y_dir_q;
  logic [15:0] x_set_q, y_set_q;
  logic [15:0] nx_q, ny_q;
  logic        hx_q, hy_q;
  logic [2:0]  color_q;
  logic        upd_q, bounce_q;

  logic [15:0] nx_d, ny_d;
  logic [3:0]  div_d;
  logic        div_fire_d;
  logic [2:0]  color_d;

  assign nx_d       = x_dir_q ? x_set_q + 16'd1 : x_set_q - 16'd1;
  assign ny_d       = y_dir_q ? y_set_q + 16'd1 : y_set_q - 16'd1;
  assign div_d      = (speed_i == 4'd0) ? 4'd1 : speed_i;
  // 5-bit compare so frame_cnt = 15 cannot wrap past the divisor
  assign div_fire_d = ({1'b0, frame_cnt_q} + 5'd1) >= {1'b0, div_d};

  always_comb begin
    color_d = RED;
    case (color_q)
      RED:     color_d = GREEN;
      GREEN:   color_d = BLUE;
      BLUE:    color_d = YELLOW;
      YELLOW:  color_d = CYAN;
      CYAN:    color_d = PURPLE;
      PURPLE:  color_d = RED;
      default: color_d = RED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_WAIT;
      frame_cnt_q <= 4'd0;
      x_dir_q     <= 1'b1;
      y_dir_q     <= 1'b1;
      x_set_q     <= X_LO;
      y_set_q     <= Y_LO;
      nx_q        <= X_LO;
      ny_q        <= Y_LO;
      hx_q        <= 1'b0;
      hy_q        <= 1'b0;
      color_q     <= RED;
      upd_q       <= 1'b0;
      bounce_q    <= 1'b0;
    end else begin
      upd_q    <= 1'b0;
      bounce_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (!enable_i) begin
            frame_cnt_q <= 4'd0;
          end else if (frame_start_i) begin
            if (div_fire_d) begin
              frame_cnt_q <= 4'd0;
              state_q     <= S_MOVE_X;
            end else begin
              frame_cnt_q <= frame_cnt_q + 4'd1;
            end
          end
        end
        S_MOVE_X: begin
          nx_q <= nx_d;
          if (nx_d == X_HI) begin
            x_dir_q <= 1'b0;
            hx_q    <= 1'b1;
          end else if (nx_d == X_LO) begin
            x_dir_q <= 1'b1;
            hx_q    <= 1'b1;
          end else begin
            hx_q <= 1'b0;
          end
          state_q <= S_MOVE_Y;
        end
        S_MOVE_Y: begin
          ny_q <= ny_d;
          if (ny_d == Y_HI) begin
            y_dir_q <= 1'b0;
            hy_q    <= 1'b1;
          end else if (ny_d == Y_LO) begin
            y_dir_q <= 1'b1;
            hy_q    <= 1'b1;
          end else begin
            hy_q <= 1'b0;
          end
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          x_set_q <= nx_q;
          y_set_q <= ny_q;
          // a corner hit sets both flags but advances the colour only once
          if (hx_q | hy_q) color_q <= color_d;
          upd_q    <= 1'b1;
          bounce_q <= hx_q | hy_q;
          state_q  <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign x_set_o  = x_set_q;
  assign y_set_o  = y_set_q;
  assign color_o  = color_q;
  assign upd_o    = upd_q;
  assign bounce_o = bounce_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: three parameterisations driven in lockstep and
// compared each frame against a pixel-walk / colour-table reference model.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  speed = 4'd1;

  logic [15:0] xs [3];
  logic [15:0] ys [3];
  logic [2:0]  cs [3];
  logic        up [3];
  logic        bo [3];

  always #5 clk = ~clk;

  sprite_motion_ctrl u_dflt (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .enable_i(enable),
    .speed_i(speed), .x_set_o(xs[0]), .y_set_o(ys[0]), .color_o(cs[0]),
    .upd_o(up[0]), .bounce_o(bo[0]));

  sprite_motion_ctrl #(.X_MIN(0), .X_MAX(10), .Y_MIN(0), .Y_MAX(20),
                       .P_WIDTH(4), .P_DEPTH(4)) u_edge (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .enable_i(enable),
    .speed_i(speed), .x_set_o(xs[1]), .y_set_o(ys[1]), .color_o(cs[1]),
    .upd_o(up[1]), .bounce_o(bo[1]));

  sprite_motion_ctrl #(.X_MIN(0), .X_MAX(10), .Y_MIN(0), .Y_MAX(10),
                       .P_WIDTH(4), .P_DEPTH(4)) u_corner (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .enable_i(enable),
    .speed_i(speed), .x_set_o(xs[2]), .y_set_o(ys[2]), .color_o(cs[2]),
    .upd_o(up[2]), .bounce_o(bo[2]));

  // reference model: legal position ranges and the colour wheel
  int          XL [3] = '{216, 0, 0};
  int          XH [3] = '{888, 6, 6};
  int          YL [3] = '{27, 0, 0};
  int          YH [3] = '{499, 16, 6};
  logic [2:0]  wheel [6] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101};

  int  mx [3], my [3], ci [3];
  bit  dx [3], dy [3];
  bit  mhit [3];
  int  fc;
  logic [6:0] um [3], bm [3];
  int  n_chk = 0;
  int  n_pass = 0;
  int  upd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    fc = 0;
    for (int k = 0; k < 3; k++) begin
      mx[k] = XL[k]; my[k] = YL[k]; dx[k] = 1; dy[k] = 1; ci[k] = 0; mhit[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit h;
    h = 0;
    mx[k] = dx[k] ? mx[k] + 1 : mx[k] - 1;
    if (mx[k] == XH[k]) begin dx[k] = 0; h = 1; end
    else if (mx[k] == XL[k]) begin dx[k] = 1; h = 1; end
    my[k] = dy[k] ? my[k] + 1 : my[k] - 1;
    if (my[k] == YH[k]) begin dy[k] = 0; h = 1; end
    else if (my[k] == YL[k]) begin dy[k] = 1; h = 1; end
    if (h) ci[k] = (ci[k] + 1) % 6;
    mhit[k] = h;
  endtask

  // one frame_start pulse; watch six following cycles on every DUT
  task automatic frame(input bit extra, input bit drop_en);
    bit fire;
    int d;
    @(negedge clk);
    frame_start = 1'b1;
    fire = 0;
    if (!enable) fc = 0;
    else begin
      d = (speed == 0) ? 1 : int'(speed);
      if (fc + 1 >= d) begin fc = 0; fire = 1; end
      else fc++;
    end
    for (int k = 0; k < 3; k++) begin um[k] = '0; bm[k] = '0; end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        frame_start = 1'b0;
        if (drop_en) begin enable = 1'b0; fc = 0; end
      end
      if (i == 2 && extra && fire) frame_start = 1'b1;
      if (i == 3) frame_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        um[k][i] = up[k];
        bm[k][i] = bo[k];
      end
    end
    for (int k = 0; k < 3; k++) begin
      mhit[k] = 0;
      if (fire) model_step(k);
      chk($sformatf("upd_timing[%0d]", k), 32'(um[k]), fire ? 32'h10 : 32'h0);
      chk($sformatf("bounce[%0d]", k), 32'(bm[k]), (fire && mhit[k]) ? 32'h10 : 32'h0);
      chk($sformatf("x_set[%0d]", k), 32'(xs[k]), 32'(mx[k]));
      chk($sformatf("y_set[%0d]", k), 32'(ys[k]), 32'(my[k]));
      chk($sformatf("color[%0d]", k), 32'(cs[k]), 32'(wheel[ci[k]]));
    end
    upd_seen += (um[0] != 0) ? 1 : 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_x[%0d]", k), 32'(xs[k]), 32'(XL[k]));
      chk($sformatf("rst_y[%0d]", k), 32'(ys[k]), 32'(YL[k]));
      chk($sformatf("rst_color[%0d]", k), 32'(cs[k]), 32'b100);
      chk($sformatf("rst_upd_bounce[%0d]", k), 32'({up[k], bo[k]}), 32'd0);
    end

    // free run, speed 1, pulses 50 clocks apart
    speed = 4'd1; enable = 1'b1;
    for (int f = 1; f <= 20; f++) begin
      idle(43);
      frame(0, 0);
      if (f == 6) begin
        chk("edge6_x", 32'(xs[1]), 32'd6);
        chk("edge6_bounce", 32'(bm[1]), 32'h10);
        chk("edge6_color", 32'(cs[1]), 32'b010);
        chk("corner6_bounce", 32'(bm[2]), 32'h10);
        chk("corner6_color", 32'(cs[2]), 32'b010);
      end
      if (f == 7)  chk("edge7_x", 32'(xs[1]), 32'd5);
      if (f == 12) begin
        chk("edge12_x", 32'(xs[1]), 32'd0);
        chk("edge12_color", 32'(cs[1]), 32'b001);
      end
    end
    chk("run20_x", 32'(xs[0]), 32'd236);
    chk("run20_y", 32'(ys[0]), 32'd47);

    // divider: speed 3 over 9 frames
    speed = 4'd3;
    upd_seen = 0;
    for (int f = 1; f <= 9; f++) begin
      idle(3);
      frame(0, 0);
      if (f == 3 || f == 6 || f == 9) chk("div3_frame", 32'(um[0]), 32'h10);
    end
    chk("div3_count", 32'(upd_seen), 32'd3);

    // speed 0 behaves as 1, with a stray frame_start mid-sequence
    speed = 4'd0;
    upd_seen = 0;
    for (int f = 0; f < 3; f++) begin idle(2); frame(1, 0); end
    chk("speed0_count", 32'(upd_seen), 32'd3);

    // enable low: nothing moves
    speed = 4'd1; enable = 1'b0;
    upd_seen = 0;
    for (int f = 0; f < 5; f++) begin idle(2); frame(0, 0); end
    chk("disabled_count", 32'(upd_seen), 32'd0);
    enable = 1'b1;

    // enable drop during the sequence still commits
    idle(2);
    frame(0, 1);
    enable = 1'b1;

    // reset while in MOVE_Y
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_x[%0d]", k), 32'(xs[k]), 32'(XL[k]));
      chk($sformatf("midrst_y[%0d]", k), 32'(ys[k]), 32'(YL[k]));
      chk($sformatf("midrst_color[%0d]", k), 32'(cs[k]), 32'b100);
    end
    upd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      upd_seen += up[0] ? 1 : 0;
    end
    idle(6);
    chk("midrst_no_upd", 32'(upd_seen), 32'd0);
    frame(0, 0);
    chk("postrst_x", 32'(xs[0]), 32'd217);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      speed  = 4'($urandom_range(0, 4));
      enable = ($urandom_range(0, 3) != 0);
      idle($urandom_range(0, 5));
      frame($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion and colour scheduler for the bouncing-sprite VGA screen saver. It owns the sprite origin (`x_set`, `y_set`) and draw colour consumed by the pixel renderer. It advances them one pixel per update, only during vertical blanking, so a frame is never drawn with a half-updated position. The block sits between the VGA timing generator, which supplies `frame_start`, and the ROM-driven pixel renderer, replacing free-running delay counters with a deterministic, frame-locked sequencer.

## Interface

Parameters:
- `X_MIN`, default 216: first active pixel column, also the left bounce limit.
- `X_MAX`, default 1016: one past the last active column.
- `Y_MIN`, default 27: first active line, also the top bounce limit.
- `Y_MAX`, default 627: one past the last active line.
- `P_WIDTH`, default 128: sprite width in pixels.
- `P_DEPTH`, default 128: sprite height in lines.
- Legal only if `X_MAX - X_MIN > P_WIDTH` and `Y_MAX - Y_MIN > P_DEPTH`.

Ports:
- `clk` in 1: system pixel clock, 40 MHz.
- `rst` in 1: asynchronous reset, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `enable` in 1: motion enable, level.
- `speed` in 4: frames per update step; 0 is treated as 1.
- `x_set` out 16: sprite left column, registered.
- `y_set` out 16: sprite top line, registered.
- `color` out 3: `{R,G,B}` draw colour, registered.
- `upd` out 1: one-cycle pulse when new `x_set`/`y_set`/`color` are committed.
- `bounce` out 1: one-cycle pulse, coincident with `upd`, when the commit included an edge hit.

## Operation

- States: WAIT, MOVE_X, MOVE_Y, COMMIT. Reset state is WAIT.
- Internal registers: `frame_cnt[3:0]`, `x_dir`, `y_dir` (1 = increasing), shadows `nx`, `ny`, and hit flags `hx`, `hy`.

Frame divider:
- Applies in WAIT on `frame_start` with `enable`=1.
- `div` = (`speed`==0) ? 1 : `speed`.
- If `frame_cnt + 1 >= div`: clear `frame_cnt` and go to MOVE_X. Otherwise increment `frame_cnt` and stay in WAIT.
- With `enable`=0: `frame_cnt` is held at 0, the FSM stays in WAIT, and all outputs hold.
- A change to `speed` takes effect at the next compare.

MOVE_X:
- `nx` = `x_set` + 1 if `x_dir`, else `x_set` − 1.
- If `nx == X_MAX − P_WIDTH`: `x_dir`←0, `hx`←1.
- Else if `nx == X_MIN`: `x_dir`←1, `hx`←1.
- Else `hx`←0.

MOVE_Y:
- Same rule using `ny`, `y_dir`, `hy`, with `Y_MIN` and `Y_MAX − P_DEPTH`.

COMMIT:
- `x_set`←`nx`, `y_set`←`ny`.
- If `hx|hy`, `color` advances one step in the sequence RED 100 → GREEN 010 → BLUE 001 → YELLOW 110 → CYAN 011 → PURPLE 101 → RED.
- Any illegal `color` value goes to RED.
- A corner hit (`hx` and `hy`) advances the colour exactly once.
- Next state is WAIT.

Other rules:
- `frame_start` arriving in MOVE_X, MOVE_Y or COMMIT is ignored and does not count toward the divider.
- All arithmetic is 16-bit unsigned. Positions never leave [`X_MIN`, `X_MAX − P_WIDTH`] and [`Y_MIN`, `Y_MAX − P_DEPTH`].
- Reset values: `x_set`=`X_MIN`, `y_set`=`Y_MIN`, `color`=RED, `upd`=0, `bounce`=0, `x_dir`=`y_dir`=1, `frame_cnt`=0, state WAIT.

## Timing

- `frame_start` is sampled high in cycle T and the divider fires. The FSM is in MOVE_X at T+1, MOVE_Y at T+2 and COMMIT at T+3.
- New `x_set`, `y_set`, `color` become visible at T+4, with `upd` (and `bounce` if hit) high during T+4 only.
- Total latency is 4 clocks, far inside blanking. Outputs are stable for every active line of the following frame.
- `rst` asserted in any state: every output and internal register returns to its reset value asynchronously, and no `upd` is issued for an interrupted sequence.
- The first update after `rst` release requires a fresh `frame_start`.
- `enable` dropping during MOVE_X…COMMIT does not abort the sequence; it completes and commits.

## Test plan

- Reset: hold `rst` for 3 clocks, release. Expect `x_set`=216, `y_set`=27, `color`=100, `upd`=`bounce`=0.
- Free run, `speed`=1, 20 `frame_start` pulses spaced 50 clocks apart. Expect `x_set`=236, `y_set`=47 and 20 `upd` pulses, each exactly 4 clocks after its `frame_start`.
- Edge bounce, with `X_MIN`=0, `X_MAX`=10, `P_WIDTH`=4, `Y_MIN`=0, `Y_MAX`=20, `P_DEPTH`=4, `speed`=1.
  - After 6 updates: `x_set`=6, `bounce`=1, `color`=010.
  - The next update gives `x_set`=5.
  - After 12 updates: `x_set`=0 and a second colour advance to 001.
- Corner: with `X_MAX`=`Y_MAX`=10 and `P_WIDTH`=`P_DEPTH`=4, the 6th update hits both edges. Expect a single `bounce` pulse and `color` 100→010 only.
- Divider and enable:
  - `speed`=3 with 9 frames gives 3 updates, on frames 3, 6 and 9.
  - `speed`=0 behaves like `speed`=1.
  - `enable`=0 for 5 frames leaves the outputs unchanged and produces no `upd`.
- Reset mid-sequence: assert `rst` during MOVE_Y. Expect immediate reset values, no `upd`, and a normal 4-clock update after the next `frame_start`.
